if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//   Instruction-fetch stage: generates PC, drives synchronous instruction ROM, buffers returned
//   words with their PC in a small FIFO, presents one {pc,inst} per cycle to the decode stage.
//   Sits upstream of decode: if_pc_o/if_inst_o feed decode's pc_i/inst_i.
//   Handles downstream stall and branch/jump redirect (flush); sustains 1 inst/cycle unstalled.
// PARAMETERS
//   RESET_PC    32'h0000_0000  first fetch address after reset
//   FIFO_DEPTH  2              buffer entries (>=2 for full throughput)
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   reset, synchronous, active-high
//   stall_i        in   1   decode cannot accept this cycle
//   redirect_i     in   1   branch/jump taken: flush and refetch
//   redirect_pc_i  in   32  new fetch address, bits [1:0] ignored
//   rom_ce_o       out  1   ROM read enable this cycle
//   rom_addr_o     out  32  ROM word address (byte addr, [1:0]=0)
//   rom_data_i     in   32  ROM data, valid cycle after rom_ce_o=1
//   if_valid_o     out  1   if_pc_o/if_inst_o hold a real instruction
//   if_pc_o        out  32  PC of presented instruction
//   if_inst_o      out  32  presented instruction; 32'h0 (NOP) when !if_valid_o
// BEHAVIOUR
// - Reset (rst=1 at edge): fetch_pc<=RESET_PC, FIFO empty, inflight<=0, drop<=0.
//   While rst=1: rom_ce_o=0, rom_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0. rst beats all.
// - pop = if_valid_o & ~stall_i & ~redirect_i.
// - Issue: rom_ce_o = ~rst & ~redirect_i & (count + inflight - pop < FIFO_DEPTH);
//   rom_addr_o = fetch_pc. On issue: fetch_pc <= fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0),
//   inflight<=1, req_pc<=fetch_pc. No issue: inflight<=0.
// - Return: cycle after issue, if inflight & ~drop & ~redirect_i: push {req_pc,rom_data_i}.
//   Credit rule guarantees push never hits full FIFO; push & pop same cycle legal at any count.
// - Latency: issue in cycle N -> if_valid_o=1 in N+2. Unstalled steady state: 1 inst/cycle.
// - Stall: head held stable (pc,inst unchanged) while stall_i=1; issue stops at credit limit,
//   no word lost or duplicated; resume order strictly sequential.
// - Redirect (edge with redirect_i=1, rst=0): FIFO cleared, fetch_pc <= {redirect_pc_i[31:2],2'b00},
//   no issue that cycle, in-flight response (if any) discarded (drop<=inflight for one return).
//   First redirect target issued N+1, visible N+3. Redirect overrides stall and pop.
// - Back-to-back redirects: last one wins; no stale word ever presented.
// - Empty: if_valid_o=0, if_pc_o=0, if_inst_o=0. Full: rom_ce_o=0 until a pop.
// - Counters: count width $clog2(FIFO_DEPTH+1); PC adder 32-bit, carry discarded.
// STRUCTURE
//   Shared define file: InstAddrBus, InstBus, ZeroWord, RstEnable, ChipEnable/ChipDisable.
//   One sub-module: fetch_fifo (params WIDTH=64, DEPTH; push/pop/flush, sync rst, count,
//   head data, empty/full; same-cycle push+pop on empty not bypassed).
//   Top holds fetch_pc, req_pc, inflight, drop, issue/credit logic, output gating.
// TESTING
// - Reset release, ROM returns addr as data: rom_addr 0,4,8 on cycles 0,1,2;
//   if_valid_o first 1 at cycle 2 with pc=0; then pc 4,8,... one per cycle.
// - stall_i=1 for 5 cycles at pc=8: if_pc_o stays 8, rom_ce_o drops after <=2 issues,
//   release -> 8,12,16 contiguous, no gaps, no repeats.
// - redirect_i at pc=0x10 to 0x103: next presented pc=0x100 (3 cycles later),
//   words 0x14/0x18 in FIFO/in flight never appear.
// - redirect during stall with full FIFO + inflight: all flushed, pc=0x200 stream follows.
// - Two redirects consecutive (0x40 then 0x80): only 0x80,0x84.. presented.
// - RESET_PC=32'hFFFF_FFF8: presents FFFF_FFF8, FFFF_FFFC, 0000_0000.
// - rst asserted mid-stream with inflight: next cycle all outputs 0; restart from RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus types, canonical constants and PC alignment helper.
package if_fetch_pkg;

  typedef logic [31:0] inst_addr_bus_t;
  typedef logic [31:0] inst_bus_t;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Byte address to word address; the two low bits carry no meaning for fetch.
  function automatic inst_addr_bus_t word_align(input inst_addr_bus_t addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {pc,inst} pairs; flush and reset empty it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, credit-limited ROM issue, return buffering and
// redirect/stall handling, presenting one {pc,inst} per cycle to decode.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  inst_addr_bus_t fetch_pc;
  inst_addr_bus_t req_pc;
  logic           inflight;
  logic           drop;

  logic [63:0]    fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;

  logic           valid;
  logic           pop;
  logic           push;
  logic           issue;
  logic [CW:0]    credit_used;

  assign valid = (rst != RST_ENABLE) & ~fifo_empty;
  assign pop   = valid & ~stall_i & ~redirect_i;

  // Slots already spoken for: buffered words plus the one returning now, minus the one leaving.
  // Issuing only below the depth means a returning word always finds room.
  assign credit_used = {1'b0, fifo_count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue = (rst != RST_ENABLE) & ~redirect_i & (credit_used < (CW + 1)'(FIFO_DEPTH));

  assign push = (rst != RST_ENABLE) & inflight & ~drop & ~redirect_i & (~fifo_full | pop);

  assign rom_ce_o   = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = (rst == RST_ENABLE) ? ZERO_WORD : fetch_pc;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= issue;
      drop     <= redirect_i & inflight;
      if (redirect_i)  fetch_pc <= word_align(redirect_pc_i);
      else if (issue)  fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc <= fetch_pc;
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata ({req_pc, rom_data_i}),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign if_valid_o = valid;
  assign if_pc_o    = valid ? fifo_head[63:32] : ZERO_WORD;
  assign if_inst_o  = valid ? fifo_head[31:0]  : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: startup, stall, redirects, reset mid-stream and PC wrap.
module tb_if_fetch;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_data;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  logic        rst_w, stall_w, redirect_w;
  logic [31:0] redirect_pc_w;
  logic        rom_ce_w;
  logic [31:0] rom_addr_w, rom_data_w;
  logic        if_valid_w;
  logic [31:0] if_pc_w, if_inst_w;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst_w), .stall_i(stall_w), .redirect_i(redirect_w),
    .redirect_pc_i(redirect_pc_w),
    .rom_ce_o(rom_ce_w), .rom_addr_o(rom_addr_w), .rom_data_i(rom_data_w),
    .if_valid_o(if_valid_w), .if_pc_o(if_pc_w), .if_inst_o(if_inst_w)
  );

  // Synchronous ROMs: each word is its address XOR a key, so pc and inst are distinguishable.
  always_ff @(posedge clk) begin
    if (rom_ce)   rom_data   <= rom_addr ^ KEY;
    if (rom_ce_w) rom_data_w <= rom_addr_w ^ KEY;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] rp);
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_pc = rp;
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v));
    chk({tag, ".pc"},    if_pc,   v ? pc : 32'h0);
    chk({tag, ".inst"},  if_inst, v ? (pc ^ KEY) : 32'h0);
  endtask

  task automatic rom(input string tag, input logic ce, input logic [31:0] addr);
    chk({tag, ".ce"}, 32'(rom_ce), 32'(ce));
    if (ce) chk({tag, ".addr"}, rom_addr, addr);
  endtask

  task automatic outw(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(if_valid_w), 32'h1);
    chk({tag, ".pc"},    if_pc_w,   pc);
    chk({tag, ".inst"},  if_inst_w, pc ^ KEY);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst_w = 1'b1; stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0;

    cyc(1, 0, 0, 0);
    out("rst", 0, 0); rom("rst", 0, 0); chk("rst.addr", rom_addr, 32'h0);

    // Startup: addresses 0,4,8 then first instruction two cycles after first issue
    @(negedge clk); rst_w = 1'b0;
    rst = 1'b0; #1;
    rom("c0", 1, 32'h0);  out("c0", 0, 0);
    cyc(0, 0, 0, 0); rom("c1", 1, 32'h4);  out("c1", 0, 0);
    cyc(0, 0, 0, 0); rom("c2", 1, 32'h8);  out("c2", 1, 32'h0);  outw("w2", 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0); out("c3", 1, 32'h4);  outw("w3", 32'hFFFF_FFFC);

    // Stall for five cycles while pc=8 is presented
    cyc(0, 1, 0, 0); out("c4", 1, 32'h8);  rom("c4", 0, 0);  outw("w4", 32'h0);
    for (int i = 5; i <= 8; i++) begin
      cyc(0, 1, 0, 0); out($sformatf("c%0d", i), 1, 32'h8); rom($sformatf("c%0d", i), 0, 0);
    end
    cyc(0, 0, 0, 0); out("c9", 1, 32'h8);  rom("c9", 1, 32'h10);
    cyc(0, 0, 0, 0); out("c10", 1, 32'hC); rom("c10", 1, 32'h14);

    // Redirect at pc=0x10 to unaligned 0x103
    cyc(0, 0, 1, 32'h103); out("c11", 1, 32'h10); rom("c11", 0, 0);
    cyc(0, 0, 0, 0); out("c12", 0, 0); rom("c12", 1, 32'h100);
    cyc(0, 0, 0, 0); out("c13", 0, 0); rom("c13", 1, 32'h104);
    cyc(0, 0, 0, 0); out("c14", 1, 32'h100);

    // Fill the buffer under stall, then redirect while still stalled
    cyc(0, 1, 0, 0); out("c15", 1, 32'h104); rom("c15", 0, 0);
    cyc(0, 1, 0, 0); out("c16", 1, 32'h104); rom("c16", 0, 0);
    cyc(0, 1, 1, 32'h200); out("c17", 1, 32'h104); rom("c17", 0, 0);
    cyc(0, 0, 0, 0); out("c18", 0, 0); rom("c18", 1, 32'h200);
    cyc(0, 0, 0, 0); out("c19", 0, 0); rom("c19", 1, 32'h204);
    cyc(0, 0, 0, 0); out("c20", 1, 32'h200);
    cyc(0, 0, 0, 0); out("c21", 1, 32'h204);

    // Back-to-back redirects: last one wins
    cyc(0, 0, 1, 32'h40); out("c22", 1, 32'h208); rom("c22", 0, 0);
    cyc(0, 0, 1, 32'h80); out("c23", 0, 0); rom("c23", 0, 0);
    cyc(0, 0, 0, 0); out("c24", 0, 0); rom("c24", 1, 32'h80);
    cyc(0, 0, 0, 0); out("c25", 0, 0); rom("c25", 1, 32'h84);
    cyc(0, 0, 0, 0); out("c26", 1, 32'h80);
    cyc(0, 0, 0, 0); out("c27", 1, 32'h84);

    // Reset mid-stream with a request in flight
    cyc(1, 0, 0, 0); out("c28", 0, 0); rom("c28", 0, 0); chk("c28.addr", rom_addr, 32'h0);
    cyc(0, 0, 0, 0); out("c29", 0, 0); rom("c29", 1, 32'h0);
    cyc(0, 0, 0, 0); out("c30", 0, 0); rom("c30", 1, 32'h4);
    cyc(0, 0, 0, 0); out("c31", 1, 32'h0);
    cyc(0, 0, 0, 0); out("c32", 1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
